sram_req_arbiter: RTL and testbench

Shares one SRAM-like memory port between the instruction-fetch master (IF stage) and the data-access master (EX/MEM stages) of the five-stage CPU. It uses the req/addr_ok/data_ok split-transaction handshake. It grants one address phase per cycle and locks a pending grant until it is accepted. It tracks up to OUTSTANDING accepted transactions in an in-order ID FIFO, which routes each mem_data_ok back to the master that issued the transaction. It sits between mycpu's stage logic and the external memory bridge.

---
 rtl/sram_req_arbiter.sv | 160 ++++++++++++++++
 tb/tb_sram_req_arbiter.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_req_arbiter.sv
// Two-master (IF fetch / EX-MEM data) arbiter onto one SRAM-like req/addr_ok/data_ok port.
// Define SRAM_ARB_RR_EN for round-robin arbitration; fixed data-first priority otherwise.
module sram_req_arbiter #(
    parameter int unsigned OUTSTANDING = 4
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [3:0]  inst_wstrb,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata,

    output logic        resp_err
);

    localparam int unsigned PtrW = $clog2(OUTSTANDING);
    localparam int unsigned CntW = PtrW + 1;

    typedef enum logic [1:0] {
        LkNone = 2'd0,
        LkInst = 2'd1,
        LkData = 2'd2
    } lock_e;

    lock_e                  lock_q;
    logic [CntW-1:0]        count_q;
    logic [CntW-1:0]        count_d;
    logic [PtrW-1:0]        wptr_q;
    logic [PtrW-1:0]        rptr_q;
    logic [OUTSTANDING-1:0] ids_q;
    logic                   resp_err_q;

    logic gnt_data;
    logic gnt_req;
    logic prefer_data;
    logic accept;
    logic fifo_empty;
    logic pop;
    logic spurious;
    logic lock_dropped;

`ifdef SRAM_ARB_RR_EN
    logic last_data_q;
    assign prefer_data = ~last_data_q;
`else
    assign prefer_data = 1'b1;
`endif

    // A held lock only steers the grant while its owner still requests.
    always_comb begin
        gnt_data = 1'b0;
        if (lock_q == LkInst && inst_req) begin
            gnt_data = 1'b0;
        end else if (lock_q == LkData && data_req) begin
            gnt_data = 1'b1;
        end else if (inst_req && data_req) begin
            gnt_data = prefer_data;
        end else begin
            gnt_data = data_req;
        end
    end

    assign gnt_req    = gnt_data ? data_req : inst_req;
    assign mem_req    = resetn & gnt_req & (count_q < CntW'(OUTSTANDING));
    assign accept     = mem_req & mem_addr_ok;
    assign fifo_empty = (count_q == '0);
    assign pop        = resetn & mem_data_ok & ~fifo_empty;
    assign spurious   = resetn & mem_data_ok & fifo_empty;

    assign lock_dropped = (lock_q == LkInst && !inst_req) || (lock_q == LkData && !data_req);

    assign mem_wr    = gnt_data ? data_wr    : inst_wr;
    assign mem_size  = gnt_data ? data_size  : inst_size;
    assign mem_wstrb = gnt_data ? data_wstrb : inst_wstrb;
    assign mem_addr  = gnt_data ? data_addr  : inst_addr;
    assign mem_wdata = gnt_data ? data_wdata : inst_wdata;

    assign inst_addr_ok = accept & ~gnt_data;
    assign data_addr_ok = accept &  gnt_data;
    assign inst_data_ok = pop & ~ids_q[rptr_q];
    assign data_data_ok = pop &  ids_q[rptr_q];
    assign inst_rdata   = mem_rdata;
    assign data_rdata   = mem_rdata;
    assign resp_err     = resp_err_q;

    always_comb begin
        count_d = count_q;
        case ({accept, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    // resetn is expected to be released synchronously by the upstream reset synchroniser.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lock_q     <= LkNone;
            count_q    <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            ids_q      <= '0;
            resp_err_q <= 1'b0;
`ifdef SRAM_ARB_RR_EN
            last_data_q <= 1'b0;
`endif
        end else begin
            count_q <= count_d;
            if (accept) begin
                ids_q[wptr_q] <= gnt_data;
                wptr_q        <= wptr_q + PtrW'(1);
            end
            if (pop) begin
                rptr_q <= rptr_q + PtrW'(1);
            end
            if (spurious) begin
                resp_err_q <= 1'b1;
            end
            if (accept) begin
                lock_q <= LkNone;
            end else if (mem_req) begin
                lock_q <= gnt_data ? LkData : LkInst;
            end else if (lock_dropped) begin
                lock_q <= LkNone;
            end
`ifdef SRAM_ARB_RR_EN
            if (accept) begin
                last_data_q <= gnt_data;
            end
`endif
        end
    end

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Self-checking bench for sram_req_arbiter: queue-based reference model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_sram_req_arbiter;

    localparam int unsigned OUTSTANDING = 4;
`ifdef SRAM_ARB_RR_EN
    localparam bit RrEn = 1'b1;
`else
    localparam bit RrEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        inst_req = 1'b0, inst_wr = 1'b0;
    logic [1:0]  inst_size = 2'd2;
    logic [3:0]  inst_wstrb = 4'h0;
    logic [31:0] inst_addr = '0, inst_wdata = '0;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req = 1'b0, data_wr = 1'b0;
    logic [1:0]  data_size = 2'd2;
    logic [3:0]  data_wstrb = 4'h0;
    logic [31:0] data_addr = '0, data_wdata = '0;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        mem_req, mem_wr;
    logic [1:0]  mem_size;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_addr_ok = 1'b0, mem_data_ok = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        resp_err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sram_req_arbiter #(.OUTSTANDING(OUTSTANDING)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .inst_req     (inst_req),
        .inst_wr      (inst_wr),
        .inst_size    (inst_size),
        .inst_wstrb   (inst_wstrb),
        .inst_addr    (inst_addr),
        .inst_wdata   (inst_wdata),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_wstrb   (data_wstrb),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .mem_req      (mem_req),
        .mem_wr       (mem_wr),
        .mem_size     (mem_size),
        .mem_wstrb    (mem_wstrb),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_addr_ok  (mem_addr_ok),
        .mem_data_ok  (mem_data_ok),
        .mem_rdata    (mem_rdata),
        .resp_err     (resp_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: in-order queue of master IDs, lock owner (-1 = none), last grant.
    int q[$];
    int lk_m   = -1;
    int last_m = 0;
    bit err_m  = 1'b0;
    int e_g;
    bit e_mem_req, e_accept, e_pop;
    int e_head;

    function automatic void model_eval();
        if (lk_m == 0 && inst_req)       e_g = 0;
        else if (lk_m == 1 && data_req)  e_g = 1;
        else if (inst_req && data_req)   e_g = RrEn ? (last_m == 1 ? 0 : 1) : 1;
        else                             e_g = data_req ? 1 : 0;
        e_mem_req = resetn && ((e_g == 1) ? data_req : inst_req) && (q.size() < OUTSTANDING);
        e_accept  = e_mem_req && mem_addr_ok;
        e_pop     = resetn && mem_data_ok && (q.size() > 0);
        e_head    = (q.size() > 0) ? q[0] : 0;
    endfunction

    always @(negedge resetn) begin
        q.delete();
        lk_m   = -1;
        last_m = 0;
        err_m  = 1'b0;
    end

    always @(posedge clk) begin
        if (resetn) begin
            model_eval();
            if (mem_data_ok && q.size() == 0) err_m = 1'b1;
            if (e_pop) void'(q.pop_front());
            if (e_accept) begin
                q.push_back(e_g);
                last_m = e_g;
                lk_m   = -1;
            end else if (e_mem_req) begin
                lk_m = e_g;
            end else if ((lk_m == 0 && !inst_req) || (lk_m == 1 && !data_req)) begin
                lk_m = -1;
            end
        end
    end

    always @(negedge clk) begin
        model_eval();
        check("mem_req", {31'b0, mem_req}, {31'b0, e_mem_req});
        check("inst_addr_ok", {31'b0, inst_addr_ok}, {31'b0, e_accept && e_g == 0});
        check("data_addr_ok", {31'b0, data_addr_ok}, {31'b0, e_accept && e_g == 1});
        check("inst_data_ok", {31'b0, inst_data_ok}, {31'b0, e_pop && e_head == 0});
        check("data_data_ok", {31'b0, data_data_ok}, {31'b0, e_pop && e_head == 1});
        check("resp_err", {31'b0, resp_err}, {31'b0, err_m});
        check("inst_rdata", inst_rdata, mem_rdata);
        check("data_rdata", data_rdata, mem_rdata);
        if (e_mem_req) begin
            check("mem_addr",  mem_addr,  e_g == 1 ? data_addr  : inst_addr);
            check("mem_wdata", mem_wdata, e_g == 1 ? data_wdata : inst_wdata);
            check("mem_ctrl", {25'b0, mem_wr, mem_size, mem_wstrb},
                  e_g == 1 ? {25'b0, data_wr, data_size, data_wstrb}
                           : {25'b0, inst_wr, inst_size, inst_wstrb});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        inst_req    = 1'b0;
        data_req    = 1'b0;
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b0;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            idle();
            mem_data_ok = 1'b1;
            mem_rdata   = 32'hD000_0000 + i;
        end
        tick();
        idle();
    endtask

    logic [7:0] pat;

    initial begin
        // Reset: outputs forced low even with live requests and responses.
        tick();
        inst_req    = 1'b1;
        mem_addr_ok = 1'b1;
        mem_data_ok = 1'b1;
        #3;
        check("rst_mem_req", {31'b0, mem_req}, 32'd0);
        check("rst_inst_addr_ok", {31'b0, inst_addr_ok}, 32'd0);
        check("rst_inst_data_ok", {31'b0, inst_data_ok}, 32'd0);
        check("rst_resp_err", {31'b0, resp_err}, 32'd0);
        tick();
        idle();
        resetn = 1'b1;

        // Single inst read.
        tick();
        inst_req    = 1'b1;
        inst_addr   = 32'h1C00_0000;
        mem_addr_ok = 1'b1;
        #3;
        check("t1_inst_addr_ok", {31'b0, inst_addr_ok}, 32'd1);
        check("t1_mem_addr", mem_addr, 32'h1C00_0000);
        tick();
        idle();
        tick();
        mem_data_ok = 1'b1;
        mem_rdata   = 32'h0280_0413;
        #3;
        check("t1_inst_data_ok", {31'b0, inst_data_ok}, 32'd1);
        check("t1_inst_rdata", inst_rdata, 32'h0280_0413);
        check("t1_data_data_ok", {31'b0, data_data_ok}, 32'd0);
        tick();
        idle();

        // Simultaneous requests: data first, then inst; responses in order [data, inst].
        tick();
        inst_req    = 1'b1;
        data_req    = 1'b1;
        inst_addr   = 32'h1C00_0004;
        data_addr   = 32'h8000_0010;
        mem_addr_ok = 1'b1;
        #3;
        check("t2_data_first", {31'b0, data_addr_ok}, 32'd1);
        tick();
        data_req = 1'b0;
        #3;
        check("t2_inst_second", {31'b0, inst_addr_ok}, 32'd1);
        tick();
        idle();
        mem_data_ok = 1'b1;
        #3;
        check("t2_resp0_data", {31'b0, data_data_ok}, 32'd1);
        tick();
        #3;
        check("t2_resp1_inst", {31'b0, inst_data_ok}, 32'd1);
        tick();
        idle();

        // Both keep requesting for two accepts: round-robin alternates, fixed keeps data.
        tick();
        inst_req    = 1'b1;
        data_req    = 1'b1;
        mem_addr_ok = 1'b1;
        #3;
        check("t2b_first_data", {31'b0, data_addr_ok}, 32'd1);
        tick();
        #3;
        check("t2b_second_inst", {31'b0, inst_addr_ok}, RrEn ? 32'd1 : 32'd0);
        check("t2b_second_data", {31'b0, data_addr_ok}, RrEn ? 32'd0 : 32'd1);
        drain(2);

        // Lock: inst pending for 3 cycles holds the grant against data.
        tick();
        inst_req  = 1'b1;
        inst_addr = 32'h1C00_0100;
        data_addr = 32'h8000_0000;
        for (int c = 1; c < 4; c++) begin
            tick();
            data_req    = 1'b1;
            mem_addr_ok = (c == 3);
            #3;
            check("t3_locked_addr", mem_addr, 32'h1C00_0100);
        end
        check("t3_inst_accept", {31'b0, inst_addr_ok}, 32'd1);
        tick();
        inst_req = 1'b0;
        #3;
        check("t3_data_accept", {31'b0, data_addr_ok}, 32'd1);
        check("t3_data_addr", mem_addr, 32'h8000_0000);
        drain(2);

        // Full FIFO: four accepts, then request held off until a pop has completed.
        for (int i = 0; i < 4; i++) begin
            tick();
            data_req    = 1'b1;
            data_addr   = 32'h0000_0100 + i;
            mem_addr_ok = 1'b1;
        end
        tick();
        data_addr = 32'h0000_0200;
        #3;
        check("t4_full_req", {31'b0, mem_req}, 32'd0);
        check("t4_full_addr_ok", {31'b0, data_addr_ok}, 32'd0);
        tick();
        mem_data_ok = 1'b1;
        #3;
        check("t4_full_pop_req", {31'b0, mem_req}, 32'd0);
        check("t4_pop_data_ok", {31'b0, data_data_ok}, 32'd1);
        tick();
        mem_data_ok = 1'b0;
        #3;
        check("t4_after_pop_req", {31'b0, mem_req}, 32'd1);
        drain(4);

        // Push and pop together at count=2 across eight mixed transactions.
        tick();
        inst_req    = 1'b1;
        mem_addr_ok = 1'b1;
        tick();
        inst_req = 1'b0;
        data_req = 1'b1;
        pat = 8'b1011_0010;
        for (int i = 0; i < 8; i++) begin
            tick();
            data_req    = pat[i];
            inst_req    = ~pat[i];
            inst_addr   = 32'h1C00_1000 + 4 * i;
            data_addr   = 32'h8000_1000 + 4 * i;
            mem_addr_ok = 1'b1;
            mem_data_ok = 1'b1;
            mem_rdata   = 32'hA000_0000 + i;
            #3;
            if (i == 0) check("t5_pop0_inst", {31'b0, inst_data_ok}, 32'd1);
            if (i == 1) check("t5_pop1_data", {31'b0, data_data_ok}, 32'd1);
        end
        tick();
        idle();
        mem_data_ok = 1'b1;
        #3;
        check("t5_tail0_inst", {31'b0, inst_data_ok}, 32'd1);
        tick();
        #3;
        check("t5_tail1_data", {31'b0, data_data_ok}, 32'd1);
        tick();
        idle();

        // Spurious response with empty FIFO sets a sticky error.
        tick();
        mem_data_ok = 1'b1;
        #3;
        check("t6_no_inst_ok", {31'b0, inst_data_ok}, 32'd0);
        check("t6_no_data_ok", {31'b0, data_data_ok}, 32'd0);
        tick();
        idle();
        #3;
        check("t6_err_set", {31'b0, resp_err}, 32'd1);
        tick();
        inst_req    = 1'b1;
        mem_addr_ok = 1'b1;
        tick();
        idle();
        #3;
        check("t6_err_hold", {31'b0, resp_err}, 32'd1);
        tick();
        resetn = 1'b0;
        #3;
        check("t6_err_cleared", {31'b0, resp_err}, 32'd0);
        tick();
        resetn = 1'b1;
        // The ID accepted before reset was discarded, so this response is spurious.
        tick();
        mem_data_ok = 1'b1;
        #3;
        check("t6_discarded_ok", {31'b0, inst_data_ok}, 32'd0);
        tick();
        idle();
        #3;
        check("t6_err_again", {31'b0, resp_err}, 32'd1);
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
